lvds_tx_serializer: RTL and testbench

LVDS_TX_SERIALIZER -- requirements
Module: lvds_tx_serializer

---
 rtl/lvds_tx_serializer_pkg.sv | 32 +++
 rtl/lvds_tx_serializer_oreg.sv | 29 ++
 rtl/lvds_tx_serializer.sv | 163 ++++++++++++++++
 tb/tb_lvds_tx_serializer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_serializer_pkg.sv
// Shared types and constants for the LVDS transmit serializer.
// Word 0 of a 64-bit group is its most significant 16 bits.
package lvds_tx_serializer_pkg;

    localparam int WORD_W  = 16;
    localparam int BYTE_W  = 8;
    localparam int GROUP_W = 4 * WORD_W;

    localparam logic [WORD_W-1:0] DEF_IDLE_WORD  = 16'h0000;
    localparam logic [WORD_W-1:0] DEF_TRAIN_WORD = 16'hA55A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_DATA  = 2'd2
    } tx_state_e;

    function automatic logic [WORD_W-1:0] group_word(
        input logic [GROUP_W-1:0] grp,
        input logic [1:0]         idx
    );
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = grp[63:48];
            2'd1:    w = grp[47:32];
            2'd2:    w = grp[31:16];
            default: w = grp[15:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lvds_tx_serializer_oreg.sv
// Output byte pipeline feeding the external ODDR: the LSB byte goes out on df,
// the MSB byte follows one slot later on dr.
module lvds_tx_serializer_oreg
    import lvds_tx_serializer_pkg::*;
#(
    parameter logic [WORD_W-1:0] IDLE_WORD = DEF_IDLE_WORD
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] slot_word,
    output logic [BYTE_W-1:0] df,
    output logic [BYTE_W-1:0] dr
);

    logic [BYTE_W-1:0] msb_q;

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            df    <= IDLE_WORD[BYTE_W-1:0];
            msb_q <= IDLE_WORD[WORD_W-1:BYTE_W];
            dr    <= IDLE_WORD[WORD_W-1:BYTE_W];
        end else begin
            df    <= slot_word[BYTE_W-1:0];
            msb_q <= slot_word[WORD_W-1:BYTE_W];
            dr    <= msb_q;
        end
    end

endmodule

// File: rtl/lvds_tx_serializer.sv
// LVDS transmit serializer: one 16-bit word slot per dclk, fed from a single
// 64-bit holding buffer, with link-training bursts and underflow accounting.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | emit IDLE_WORD; buffer may fill and is held
//   ST_TRAIN | emit TRAIN_WORD for TRAIN_CYCLES slots, then pulse train_done
//   ST_DATA  | stream buffered groups; empty load slot counts an underflow
module lvds_tx_serializer
    import lvds_tx_serializer_pkg::*;
#(
    parameter logic [WORD_W-1:0] IDLE_WORD    = DEF_IDLE_WORD,
    parameter logic [WORD_W-1:0] TRAIN_WORD   = DEF_TRAIN_WORD,
    parameter int unsigned       TRAIN_CYCLES = 64
) (
    input  logic               dclk,
    input  logic               rst_n,
    input  logic               tx_en,
    input  logic               train_req,
    input  logic [GROUP_W-1:0] wr_data,
    input  logic               wr_valid,
    output logic               wr_ready,
    output logic [BYTE_W-1:0]  df,
    output logic [BYTE_W-1:0]  dr,
    output logic               busy,
    output logic               train_done,
    output logic [15:0]        underflow_cnt
);

    // Counter runs TRAIN_CYCLES-1 down to 0; the slot seen at 0 is the last.
    localparam logic [15:0] TRAIN_LOAD = 16'(TRAIN_CYCLES - 1);

    tx_state_e          state_q, state_d;
    logic [GROUP_W-1:0] hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [1:0]         word_cnt_q, word_cnt_d;
    logic [15:0]        train_cnt_q, train_cnt_d;
    logic               train_pend_q, train_pend_d;
    logic [15:0]        underflow_q, underflow_d;
    logic               train_done_q, train_done_d;
    logic               rdy_q;
    logic               at_boundary;
    logic               xfer;
    logic [WORD_W-1:0]  slot_word;

    // rdy_q keeps wr_ready low while in reset and releases it on the first edge.
    assign wr_ready      = rdy_q && (!hold_full_q || (state_q == ST_DATA && word_cnt_q == 2'd3));
    assign xfer          = wr_valid && wr_ready;
    assign busy          = (state_q != ST_IDLE);
    assign train_done    = train_done_q;
    assign underflow_cnt = underflow_q;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        word_cnt_d   = word_cnt_q;
        train_cnt_d  = train_cnt_q;
        train_pend_d = train_pend_q;
        underflow_d  = underflow_q;
        train_done_d = 1'b0;
        at_boundary  = 1'b0;
        slot_word    = IDLE_WORD;

        if (train_req && state_q != ST_TRAIN) begin
            train_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (train_req || train_pend_q) begin
                    state_d      = ST_TRAIN;
                    train_cnt_d  = TRAIN_LOAD;
                    train_pend_d = 1'b0;
                end else if (tx_en) begin
                    state_d = ST_DATA;
                end
            end

            ST_TRAIN: begin
                slot_word = TRAIN_WORD;
                if (train_cnt_q == 16'd0) begin
                    train_done_d = 1'b1;
                    state_d      = tx_en ? ST_DATA : ST_IDLE;
                end else begin
                    train_cnt_d = train_cnt_q - 16'd1;
                end
            end

            ST_DATA: begin
                if (hold_full_q) begin
                    slot_word  = group_word(hold_q, word_cnt_q);
                    word_cnt_d = word_cnt_q + 2'd1;
                    if (word_cnt_q == 2'd3) begin
                        hold_full_d = 1'b0;
                        at_boundary = 1'b1;
                    end
                end else begin
                    at_boundary = 1'b1;
                    if (underflow_q != 16'hFFFF) begin
                        underflow_d = underflow_q + 16'd1;
                    end
                end

                // Mode changes only between groups so a group is never cut short.
                if (at_boundary) begin
                    if (train_req || train_pend_q) begin
                        state_d      = ST_TRAIN;
                        train_cnt_d  = TRAIN_LOAD;
                        train_pend_d = 1'b0;
                    end else if (!tx_en) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (xfer) begin
            hold_d      = wr_data;
            hold_full_d = 1'b1;
            word_cnt_d  = 2'd0;
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            word_cnt_q   <= 2'd0;
            train_cnt_q  <= 16'd0;
            train_pend_q <= 1'b0;
            underflow_q  <= 16'd0;
            train_done_q <= 1'b0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            word_cnt_q   <= word_cnt_d;
            train_cnt_q  <= train_cnt_d;
            train_pend_q <= train_pend_d;
            underflow_q  <= underflow_d;
            train_done_q <= train_done_d;
            rdy_q        <= 1'b1;
        end
    end

    lvds_tx_serializer_oreg #(
        .IDLE_WORD (IDLE_WORD)
    ) u_oreg (
        .dclk      (dclk),
        .rst_n     (rst_n),
        .slot_word (slot_word),
        .df        (df),
        .dr        (dr)
    );

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Directed vector bench for lvds_tx_serializer (TRAIN_CYCLES = 4).
module tb_lvds_tx_serializer;

    logic        dclk = 1'b0;
    logic        rst_n;
    logic        tx_en;
    logic        train_req;
    logic [63:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  df;
    logic [7:0]  dr;
    logic        busy;
    logic        train_done;
    logic [15:0] underflow_cnt;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        tx;
        logic        trq;
        logic        vld;
        logic [63:0] data;
        logic [7:0]  df;
        logic [7:0]  dr;
        logic        busy;
        logic        rdy;
        logic        td;
        logic [15:0] uf;
    } vec_t;

    vec_t vt[$];

    always #5 dclk = ~dclk;

    lvds_tx_serializer #(
        .TRAIN_CYCLES (4)
    ) dut (
        .dclk          (dclk),
        .rst_n         (rst_n),
        .tx_en         (tx_en),
        .train_req     (train_req),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .df            (df),
        .dr            (dr),
        .busy          (busy),
        .train_done    (train_done),
        .underflow_cnt (underflow_cnt)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic add(input logic tx, input logic trq, input logic vld, input logic [63:0] d,
                       input logic [7:0] edf, input logic [7:0] edr, input logic eb,
                       input logic er, input logic et, input logic [15:0] eu);
        vec_t v;
        v.tx = tx; v.trq = trq; v.vld = vld; v.data = d;
        v.df = edf; v.dr = edr; v.busy = eb; v.rdy = er; v.td = et; v.uf = eu;
        vt.push_back(v);
    endtask

    function automatic logic [63:0] outs();
        return 64'({df, dr, busy, wr_ready, train_done, underflow_cnt});
    endfunction

    localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D2 = 64'h0102_0304_0506_0708;
    localparam logic [63:0] D3 = 64'h090A_0B0C_0D0E_0F10;
    localparam logic [63:0] G  = 64'h2122_2324_2526_2728;
    localparam logic [63:0] H  = 64'h3132_3334_3536_3738;
    localparam logic [63:0] K  = 64'h4142_4344_4546_4748;
    localparam logic [63:0] M  = 64'h5152_5354_5556_5758;

    initial begin
        rst_n = 1'b0; tx_en = 1'b0; train_req = 1'b0; wr_valid = 1'b0; wr_data = '0;

        //   tx trq vld data   df     dr     busy rdy td  uf
        add(0, 0, 0, '0,  8'h00, 8'h00, 0, 1, 0, 16'd0);
        // single group, then starvation
        add(1, 0, 1, D1,  8'h00, 8'h00, 1, 0, 0, 16'd0);
        add(1, 0, 0, '0,  8'h11, 8'h00, 1, 0, 0, 16'd0);
        add(1, 0, 0, '0,  8'h22, 8'h11, 1, 0, 0, 16'd0);
        add(1, 0, 0, '0,  8'h33, 8'h22, 1, 1, 0, 16'd0);
        add(1, 0, 0, '0,  8'h44, 8'h33, 1, 1, 0, 16'd0);
        add(1, 0, 0, '0,  8'h00, 8'h44, 1, 1, 0, 16'd1);
        add(1, 0, 0, '0,  8'h00, 8'h00, 1, 1, 0, 16'd2);
        // back-to-back groups with wr_valid held
        add(1, 0, 1, D2,  8'h00, 8'h00, 1, 0, 0, 16'd3);
        add(1, 0, 1, D3,  8'h02, 8'h00, 1, 0, 0, 16'd3);
        add(1, 0, 1, D3,  8'h04, 8'h01, 1, 0, 0, 16'd3);
        add(1, 0, 1, D3,  8'h06, 8'h03, 1, 1, 0, 16'd3);
        add(1, 0, 1, D3,  8'h08, 8'h05, 1, 0, 0, 16'd3);
        add(1, 0, 0, '0,  8'h0A, 8'h07, 1, 0, 0, 16'd3);
        add(1, 0, 0, '0,  8'h0C, 8'h09, 1, 0, 0, 16'd3);
        add(1, 0, 0, '0,  8'h0E, 8'h0B, 1, 1, 0, 16'd3);
        add(0, 0, 0, '0,  8'h10, 8'h0D, 0, 1, 0, 16'd3);
        add(0, 0, 0, '0,  8'h00, 8'h0F, 0, 1, 0, 16'd3);
        add(0, 0, 0, '0,  8'h00, 8'h00, 0, 1, 0, 16'd3);
        // training from IDLE, group buffered during training
        add(1, 1, 0, '0,  8'h00, 8'h00, 1, 1, 0, 16'd3);
        add(1, 0, 0, '0,  8'h5A, 8'h00, 1, 1, 0, 16'd3);
        add(1, 0, 0, '0,  8'h5A, 8'hA5, 1, 1, 0, 16'd3);
        add(1, 0, 1, G,   8'h5A, 8'hA5, 1, 0, 0, 16'd3);
        add(1, 0, 1, H,   8'h5A, 8'hA5, 1, 0, 1, 16'd3);
        // tx_en dropped mid-group; second group held in IDLE
        add(1, 0, 1, H,   8'h22, 8'hA5, 1, 0, 0, 16'd3);
        add(0, 0, 1, H,   8'h24, 8'h21, 1, 0, 0, 16'd3);
        add(0, 0, 1, H,   8'h26, 8'h23, 1, 1, 0, 16'd3);
        add(0, 0, 1, H,   8'h28, 8'h25, 0, 0, 0, 16'd3);
        add(0, 0, 0, '0,  8'h00, 8'h27, 0, 0, 0, 16'd3);
        add(0, 0, 0, '0,  8'h00, 8'h00, 0, 0, 0, 16'd3);
        add(1, 0, 0, '0,  8'h00, 8'h00, 1, 0, 0, 16'd3);
        add(1, 0, 0, '0,  8'h32, 8'h00, 1, 0, 0, 16'd3);
        add(1, 0, 0, '0,  8'h34, 8'h31, 1, 0, 0, 16'd3);
        add(1, 0, 0, '0,  8'h36, 8'h33, 1, 1, 0, 16'd3);
        add(0, 0, 0, '0,  8'h38, 8'h35, 0, 1, 0, 16'd3);
        add(0, 0, 0, '0,  8'h00, 8'h37, 0, 1, 0, 16'd3);
        // train_req mid-group deferred to boundary; repeat request in TRAIN ignored
        add(1, 0, 1, K,   8'h00, 8'h00, 1, 0, 0, 16'd3);
        add(1, 0, 0, '0,  8'h42, 8'h00, 1, 0, 0, 16'd3);
        add(1, 1, 0, '0,  8'h44, 8'h41, 1, 0, 0, 16'd3);
        add(1, 0, 0, '0,  8'h46, 8'h43, 1, 1, 0, 16'd3);
        add(1, 0, 0, '0,  8'h48, 8'h45, 1, 1, 0, 16'd3);
        add(1, 0, 0, '0,  8'h5A, 8'h47, 1, 1, 0, 16'd3);
        add(1, 1, 0, '0,  8'h5A, 8'hA5, 1, 1, 0, 16'd3);
        add(1, 0, 0, '0,  8'h5A, 8'hA5, 1, 1, 0, 16'd3);
        add(0, 0, 0, '0,  8'h5A, 8'hA5, 0, 1, 1, 16'd3);
        add(0, 0, 0, '0,  8'h00, 8'hA5, 0, 1, 0, 16'd3);
        add(0, 0, 0, '0,  8'h00, 8'h00, 0, 1, 0, 16'd3);

        #22;
        chk("reset_state", outs(), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            tx_en     = vt[i].tx;
            train_req = vt[i].trq;
            wr_valid  = vt[i].vld;
            wr_data   = vt[i].data;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                64'({vt[i].df, vt[i].dr, vt[i].busy, vt[i].rdy, vt[i].td, vt[i].uf}));
        end

        // underflow saturation
        tx_en = 1'b1; train_req = 1'b0; wr_valid = 1'b0; wr_data = '0;
        repeat (70000) tick();
        chk("uf_saturated", 64'(underflow_cnt), 64'h0000_0000_0000_FFFF);
        chk("busy_streaming", 64'(busy), 64'd1);
        tick();
        chk("uf_stays_saturated", 64'(underflow_cnt), 64'h0000_0000_0000_FFFF);

        // asynchronous reset in the middle of a group
        wr_valid = 1'b1; wr_data = M;
        tick();
        wr_valid = 1'b0; wr_data = '0;
        tick();
        chk("mid_w0", 64'({df, dr}), 64'h0000_0000_0000_5200);
        tick();
        chk("mid_w1", 64'({df, dr}), 64'h0000_0000_0000_5451);
        tick();
        chk("mid_w2", 64'({df, dr}), 64'h0000_0000_0000_5653);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", outs(), 64'd0);
        #10;
        rst_n = 1'b1;
        chk("ready_low_before_edge", 64'(wr_ready), 64'd0);
        tick();
        chk("ready_after_first_edge", 64'({busy, wr_ready}), 64'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("no_residual%0d", i), 64'({df, dr}), 64'd0);
        end
        chk("uf_after_reset", 64'(underflow_cnt), 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
